// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight destination registers feeding the EX forwarding selects and the IF/ID load-use stall.
// Define HAZARD_STATS_EN to add the saturating stall_count_o statistics output.
module hazard_scoreboard #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          id_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]            id_rs_used_i,
    input  logic [REG_ADDR_W-1:0]         id_rd_i,
    input  logic                          id_rd_we_i,
    input  logic                          id_is_load_i,
    input  logic                          flush_i,
    input  logic                          hold_i,
    output logic                          stall_o,
    output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                   stall_count_o
`endif
);

    logic                  ent_we [0:DEPTH];
    logic [REG_ADDR_W-1:0] ent_rd [0:DEPTH];
    logic                  ent_ld [0:DEPTH];
    logic [REG_ADDR_W-1:0] ex_rs  [0:NUM_SRC-1];
    logic                  issue;

    assign issue = id_valid_i & ~flush_i & ~stall_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k <= DEPTH; k++) begin
                ent_we[k] <= 1'b0;
                ent_rd[k] <= '0;
                ent_ld[k] <= 1'b0;
            end
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
                ex_rs[j] <= '0;
            end
        end else if (!hold_i) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                ent_we[k] <= ent_we[k-1];
                ent_rd[k] <= ent_rd[k-1];
                ent_ld[k] <= ent_ld[k-1];
            end
            if (issue) begin
                // x0 writes are dropped here so no consumer can ever forward from them
                ent_we[0] <= id_rd_we_i & (id_rd_i != '0);
                ent_rd[0] <= id_rd_i;
                ent_ld[0] <= id_is_load_i;
                for (int unsigned j = 0; j < NUM_SRC; j++) begin
                    ex_rs[j] <= id_rs_used_i[j] ? id_rs_i[j*REG_ADDR_W +: REG_ADDR_W] : '0;
                end
            end else begin
                ent_we[0] <= 1'b0;
                ent_rd[0] <= '0;
                ent_ld[0] <= 1'b0;
                for (int unsigned j = 0; j < NUM_SRC; j++) begin
                    ex_rs[j] <= '0;
                end
            end
        end
    end

    // Loads in stages below LOAD_READY-1 cannot yet supply data to the next EX cycle.
    always_comb begin
        stall_o = 1'b0;
        if (id_valid_i && !flush_i) begin
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
                if (id_rs_used_i[j] && (id_rs_i[j*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
                    for (int unsigned k = 0; k + 1 < LOAD_READY; k++) begin
                        if (ent_we[k] && ent_ld[k] &&
                            (ent_rd[k] == id_rs_i[j*REG_ADDR_W +: REG_ADDR_W])) begin
                            stall_o = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Scanning oldest to youngest lets the youngest matching producer overwrite older ones.
    always_comb begin
        ex_fwd_sel_o = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (ex_rs[j] != '0) begin
                for (int unsigned k = DEPTH; k >= 1; k--) begin
                    if (ent_we[k] && (ent_rd[k] == ex_rs[j])) begin
                        ex_fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(k);
                    end
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_count_o <= '0;
        end else if (stall_o && !hold_i && (stall_count_o != '1)) begin
            stall_count_o <= stall_count_o + 32'd1;
        end
    end
`endif

endmodule
